// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_pkg
// Description : Shared types and address-mapping helper for mem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_responder_pkg;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    typedef struct packed {
        logic        in_range;
        logic [31:0] idx;
    } word_map_t;

    // The offset wraps modulo 2^32, so addresses below the base land far out of range.
    function automatic word_map_t map_addr(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int unsigned mem_words);
        word_map_t   m;
        logic [31:0] off;
        off        = addr - base;
        m.idx      = off >> 2;
        m.in_range = (off < (32'(mem_words) << 2));
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_if
// Description : Request/response handshake bundle between core and memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_responder_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : mem_array
// Description : Word array, synchronous byte-masked write, combinational read.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_array #(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned ADDR_W    = $clog2(MEM_WORDS)
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [31:0]       i_wdata,
    input  wire logic [3:0]        i_wmask,
    output logic      [31:0]       o_rdata
);

    logic [31:0] r_mem [MEM_WORDS];
    logic [31:0] w_merged;

    assign o_rdata = r_mem[i_addr];

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_merged[8*gi +: 8] = i_wmask[gi] ? i_wdata[8*gi +: 8]
                                                 : o_rdata[8*gi +: 8];
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= w_merged;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Single-outstanding memory responder with fixed response latency.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = RESET_PC,
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned LATENCY   = 2
) (
    input  wire logic      clk,
    input  wire logic      reset,
    mem_responder_if.slave bus
);

    localparam int unsigned c_addr_w    = $clog2(MEM_WORDS);
    localparam logic [3:0]  c_wait_init = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    resp_state_t r_state;
    logic [3:0]  r_count;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    word_map_t             w_map;
    logic                  w_req_ready;
    logic                  w_accept;
    logic                  w_mem_we;
    logic [31:0]           w_mem_rdata;
    logic [c_addr_w-1:0]   w_idx;
    logic                  w_unused_idx;

    assign w_map        = map_addr(bus.req_addr, BASE_ADDR, MEM_WORDS);
    assign w_idx        = w_map.idx[c_addr_w-1:0];
    assign w_unused_idx = &{1'b0, w_map.idx[31:c_addr_w]};

    // Ready is gated by reset so it drops the instant reset asserts.
    assign w_req_ready = (r_state == IDLE) && reset;
    assign w_accept    = bus.req_valid && w_req_ready;
    assign w_mem_we    = w_accept && bus.req_wen && w_map.in_range;

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

    mem_array #(
        .MEM_WORDS (MEM_WORDS),
        .ADDR_W    (c_addr_w)
    ) u_mem_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (w_idx),
        .i_wdata (bus.req_wdata),
        .i_wmask (bus.req_wmask),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_count     <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_rsp_rdata <= (!bus.req_wen && w_map.in_range) ? w_mem_rdata : 32'd0;
                        r_rsp_err   <= !w_map.in_range;
                        if (LATENCY == 1) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                            r_count <= c_wait_init;
                        end
                    end
                end
                WAIT: begin
                    if (r_count == 4'd0) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= 32'd0;
                        r_rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    a_no_valid_and_ready : assert property (@(posedge clk) disable iff (!reset)
        !(bus.rsp_valid && bus.req_ready));

    a_rsp_stable : assert property (@(posedge clk) disable iff (!reset)
        (bus.rsp_valid && !bus.rsp_ready) |=> ($stable(bus.rsp_rdata) && $stable(bus.rsp_err)));

endmodule
`default_nettype wire
